act_buf_reader: RTL and testbench
=================================

# act_buf_reader

Drains the 64-bit activation buffer BRAM and re-serialises it into an 8-bit AXI-Stream, one byte per beat. It is the read-side counterpart of the layer's activation writer. It waits for the writer's SyncSig handshake announcing a full frame, then streams `WORDS` words LSB-byte-first. It prefetches one word ahead so that a continuously ready sink sees no bubbles at word boundaries.

## Interface
Parameters:
- `DWIDTH`, 64: BRAM word width. Must be a multiple of 8.
- `AWIDTH`, 10: BRAM address width.
- `WORDS`, 544: words per frame. Range 1..2^AWIDTH.

Ports:
- `ap_clk`  in  1: single clock; all logic is on the rising edge.
- `ap_rst`  in  1: asynchronous, active-high reset.
- `SyncSig_V`  in  1: frame flag. 1 means a frame is ready; 0 is acknowledged and ignored.
- `SyncSig_V_ap_vld`  in  1: sync valid. The writer holds it until it sees ack.
- `SyncSig_V_ap_ack`  out  1: one-cycle acknowledge.
- `ActBuf_Data_address0`  out  AWIDTH: BRAM read address.
- `ActBuf_Data_ce0`  out  1: BRAM read enable.
- `ActBuf_Data_q0`  in  DWIDTH: read data. Valid the cycle after the `ce0` cycle.
- `ActOut_V_V_TDATA`  out  8: output byte.
- `ActOut_V_V_TVALID`  out  1: output valid.
- `ActOut_V_V_TREADY`  in  1: sink ready.
- `frame_done`  out  1: one-cycle pulse after the last byte handshake.

## Operation
- The FSM has two states: IDLE and RUN.
- IDLE:
  - When `SyncSig_V_ap_vld`=1, drive `ack`=1 for one cycle.
  - If `SyncSig_V`=1, go to RUN. Otherwise stay in IDLE.
- `ack` is never asserted in RUN. A sync request arriving in RUN is held off and is acknowledged on the first IDLE cycle.
- RUN datapath:
  - Read address counter `rd_addr`, range 0..WORDS.
  - Output word register `cur` with byte index `bidx` (0..DWIDTH/8-1).
  - One-entry prefetch register `nxt`, with a flag marking it full.
  - One read-in-flight flag.
- Read issue:
  - Issue `ce0`=1 at `rd_addr` when all three hold: `rd_addr` < WORDS, no read is in flight, and `nxt` is empty or being consumed this cycle.
  - Increment `rd_addr` on each issue.
  - `ce0` is 0 in every other cycle.
- Returning `q0` is loaded into `cur` if `cur` is empty or its last byte handshakes this cycle. Otherwise it is loaded into `nxt`.
- Byte order: `TDATA` = `cur[8*bidx+7 : 8*bidx]`, so byte 0 is `q0[7:0]`.
- On a handshake (`TVALID` & `TREADY`), `bidx` increments. On the last byte, `cur` refills from `nxt`, or from `q0` in the same cycle, or becomes empty.
- `TVALID` = `cur` full. Once asserted, `TVALID` and `TDATA` stay stable until the handshake.
- A frame is WORDS × DWIDTH/8 bytes. After the final handshake: return to IDLE, pulse `frame_done`, reset `rd_addr` and `bidx` to 0.
- Address never exceeds WORDS-1. There is no wrap-around within a frame.

## Timing
- Reset values: `ack`=0, `ce0`=0, `address0`=0, `TVALID`=0, `TDATA`=0, `frame_done`=0. State is IDLE and all buffers are empty.
- Reset mid-frame aborts immediately. Partial data is discarded. On release the block waits for a new sync.
- Start latency:
  - `ack` is asserted in cycle N.
  - `ce0` for address 0 is asserted in N+1.
  - `q0` is valid in N+2.
  - `TVALID`=1 from N+3.
- Throughput is 1 byte/cycle with `TREADY` held high, with no gaps across word boundaries.
- Backpressure: with `TREADY`=0, at most one word is buffered in `nxt` and reads then stall. No data is lost or duplicated.
- `frame_done` is asserted in the cycle after the last handshake. A sync `vld` pending at that cycle is acknowledged in that same cycle.

## Configuration
- `ACT_BUF_READER_TLAST_EN`
  - Defined: adds output port `ActOut_V_V_TLAST`. It is 1 together with `TVALID` on the final byte of the frame, else 0, and resets to 0.
  - Undefined: the port is absent and all other behaviour is identical.

## Test plan
- Reset, then WORDS=4, word k = 0x0706050403020100 + k·0x0808080808080808, `TREADY`=1 → `ack` in cycle N, `TVALID` from N+3, bytes 0x00..0x1F on 32 consecutive cycles, `frame_done` one cycle after byte 0x1F.
- Same frame with `TREADY` toggling 1,0,0,1… → identical byte sequence, no duplicates, `ce0` never issued while both `cur` and `nxt` are full.
- `SyncSig_V`=0 with `vld`=1 → `ack` pulses once, `TVALID` stays 0, no `ce0`.
- Second sync asserted mid-frame and held → `ack` first appears in the `frame_done` cycle, and the second frame starts 3 cycles later.
- `ap_rst` pulsed after 10 bytes of a frame → all outputs return to reset values asynchronously, and a new sync restarts at address 0 with byte 0x00.
- With `ACT_BUF_READER_TLAST_EN`, WORDS=1 → `TLAST`=1 only on the 8th byte.

Source files
------------

// File: rtl/act_buf_reader.sv
// Streams a frame of BRAM words out as bytes, LSB byte first, with one word of prefetch.
// Optional macro ACT_BUF_READER_TLAST_EN adds ActOut_V_V_TLAST on the final byte of a frame.
module act_buf_reader #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 10,
    parameter int WORDS  = 544
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              SyncSig_V,
    input  logic              SyncSig_V_ap_vld,
    output logic              SyncSig_V_ap_ack,
    output logic [AWIDTH-1:0] ActBuf_Data_address0,
    output logic              ActBuf_Data_ce0,
    input  logic [DWIDTH-1:0] ActBuf_Data_q0,
    output logic [7:0]        ActOut_V_V_TDATA,
    output logic              ActOut_V_V_TVALID,
    input  logic              ActOut_V_V_TREADY,
`ifdef ACT_BUF_READER_TLAST_EN
    output logic              ActOut_V_V_TLAST,
`endif
    output logic              frame_done
);

    localparam int NB = DWIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AWIDTH:0] WORDS_C = (AWIDTH+1)'(WORDS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [AWIDTH:0]   rd_addr;
    logic [DWIDTH-1:0] cur;
    logic [DWIDTH-1:0] nxt;
    logic              cur_full;
    logic              nxt_full;
    logic              in_flight;
    logic [BW-1:0]     bidx;

    logic hs;
    logic last_byte;
    logic cur_drain;
    logic all_issued;
    logic frame_end;
    logic issue;

    assign hs         = cur_full & ActOut_V_V_TREADY;
    assign last_byte  = (bidx == BW'(NB - 1));
    assign cur_drain  = hs & last_byte;
    assign all_issued = (rd_addr == WORDS_C);
    // The frame ends on the last byte of the last word: nothing left to issue, in flight or queued.
    assign frame_end  = cur_drain & all_issued & ~in_flight & ~nxt_full;
    assign issue      = (state == RUN) & ~all_issued & ~in_flight & (~nxt_full | cur_drain);

    // Ack is combinational so the writer can drop vld on the following edge.
    assign SyncSig_V_ap_ack     = (state == IDLE) & SyncSig_V_ap_vld & ~ap_rst;
    assign ActBuf_Data_ce0      = issue;
    assign ActBuf_Data_address0 = rd_addr[AWIDTH-1:0];
    assign ActOut_V_V_TVALID    = cur_full;
    assign ActOut_V_V_TDATA     = cur[{bidx, 3'b000} +: 8];
`ifdef ACT_BUF_READER_TLAST_EN
    assign ActOut_V_V_TLAST     = cur_full & last_byte & all_issued & ~in_flight & ~nxt_full;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            cur        <= '0;
            nxt        <= '0;
            cur_full   <= 1'b0;
            nxt_full   <= 1'b0;
            in_flight  <= 1'b0;
            bidx       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (SyncSig_V_ap_vld && SyncSig_V) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_addr <= rd_addr + {{AWIDTH{1'b0}}, 1'b1};
                    end
                    in_flight <= issue;
                    if (hs) begin
                        bidx <= last_byte ? '0 : bidx + BW'(1);
                    end
                    // A returning word always finds nxt empty, since issue waits for room.
                    if (in_flight) begin
                        if (!cur_full || cur_drain) begin
                            cur      <= ActBuf_Data_q0;
                            cur_full <= 1'b1;
                        end else begin
                            nxt      <= ActBuf_Data_q0;
                            nxt_full <= 1'b1;
                        end
                    end else if (cur_drain) begin
                        if (nxt_full) begin
                            cur      <= nxt;
                            nxt_full <= 1'b0;
                        end else begin
                            cur_full <= 1'b0;
                        end
                    end
                    if (frame_end) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        rd_addr    <= '0;
                        bidx       <= '0;
                        cur        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_buf_reader.sv
// Scoreboard bench for act_buf_reader: BRAM model, sync driver, randomized sink, byte-stream reference.
module tb_act_buf_reader;

    localparam int DWIDTH = 64;
    localparam int AWIDTH = 10;
    localparam int WORDS  = 4;
    localparam int NB     = DWIDTH / 8;
    localparam int FB     = WORDS * NB;

    logic              clk = 1'b0;
    logic              rst;
    logic              sync_v;
    logic              sync_vld;
    logic              sync_ack;
    logic [AWIDTH-1:0] addr;
    logic              ce0;
    logic [DWIDTH-1:0] q0 = '0;
    logic [7:0]        tdata;
    logic              tvalid;
    logic              tready = 1'b0;
    logic              frame_done;
`ifdef ACT_BUF_READER_TLAST_EN
    logic              tlast;
`endif

    act_buf_reader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .WORDS(WORDS)) dut (
        .ap_clk               (clk),
        .ap_rst               (rst),
        .SyncSig_V            (sync_v),
        .SyncSig_V_ap_vld     (sync_vld),
        .SyncSig_V_ap_ack     (sync_ack),
        .ActBuf_Data_address0 (addr),
        .ActBuf_Data_ce0      (ce0),
        .ActBuf_Data_q0       (q0),
        .ActOut_V_V_TDATA     (tdata),
        .ActOut_V_V_TVALID    (tvalid),
        .ActOut_V_V_TREADY    (tready),
`ifdef ACT_BUF_READER_TLAST_EN
        .ActOut_V_V_TLAST     (tlast),
`endif
        .frame_done           (frame_done)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- BRAM model ----------------
    logic [DWIDTH-1:0] mem [WORDS];
    always @(posedge clk) if (ce0) q0 <= mem[int'(addr) % WORDS];

    task automatic fill_pattern();
        for (int k = 0; k < WORDS; k++)
            mem[k] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    endtask

    task automatic fill_random();
        for (int k = 0; k < WORDS; k++) mem[k] = {$urandom, $urandom};
    endtask

    // ---------------- sink ready driver ----------------
    int mode = 0;
    int tr_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       tready = 1'b1;
            1:       tready = (tr_cnt % 3 == 0);
            default: tready = ($urandom_range(0, 3) != 0);
        endcase
        tr_cnt++;
    end

    // ---------------- scoreboard monitor ----------------
    logic [7:0] exp_q[$];
    bit         busy = 0;
    int         byte_cnt = 0;
    int         issued = 0;
    int         words_done = 0;
    bit         fd_pending = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    bit         m_hs;
    bit         m_drain;
    logic [7:0] m_exp;
    logic [DWIDTH-1:0] m_word;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy = 0; byte_cnt = 0; issued = 0; words_done = 0;
            fd_pending = 0; prev_stall = 0;
        end else begin
            m_hs    = tvalid && tready;
            m_drain = m_hs && (byte_cnt % NB == NB - 1);
            if (sync_ack) begin
                check(!busy, "ack_during_run", 64'(sync_ack), 64'd0);
                if (sync_v) begin
                    for (int w = 0; w < WORDS; w++) begin
                        m_word = mem[w];
                        for (int b = 0; b < NB; b++) exp_q.push_back(m_word[8*b +: 8]);
                    end
                    busy = 1; byte_cnt = 0; issued = 0; words_done = 0;
                end
            end
            if (frame_done || fd_pending)
                check(frame_done == fd_pending, "frame_done", 64'(frame_done), 64'(fd_pending));
            fd_pending = 0;
            if (ce0) begin
                check(busy, "ce0_while_idle", 64'(ce0), 64'd0);
                check(int'(addr) == issued && issued < WORDS, "ce0_address", 64'(addr), 64'(issued));
                check(issued - (words_done + int'(m_drain)) <= 1, "ce0_with_buffers_full",
                      64'(issued - words_done), 64'd1);
                issued++;
            end
            if (prev_stall)
                check(tvalid && tdata == prev_data, "hold_while_stalled", {55'd0, tvalid, tdata},
                      {55'd0, 1'b1, prev_data});
            if (tvalid) begin
`ifdef ACT_BUF_READER_TLAST_EN
                check(tlast == (byte_cnt == FB - 1), "tlast", 64'(tlast), 64'(byte_cnt == FB - 1));
`endif
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_tvalid", 64'(tvalid), 64'd0);
                end else if (m_hs) begin
                    m_exp = exp_q.pop_front();
                    check(tdata == m_exp, "tdata", 64'(tdata), 64'(m_exp));
                    if (m_drain) words_done++;
                    byte_cnt++;
                    if (byte_cnt == FB) begin
                        busy = 0;
                        fd_pending = 1;
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic raise_sync(input logic flag);
        @(posedge clk); #1;
        sync_vld = 1'b1;
        sync_v   = flag;
    endtask

    // Waits for ack; returns its cycle and whether frame_done was high in that cycle.
    task automatic wait_ack(output int n, output bit fd);
        n = -1; fd = 0;
        for (int i = 0; i < 300 && n < 0; i++) begin
            @(negedge clk);
            if (sync_ack) begin
                n  = cyc;
                fd = frame_done;
            end
        end
        if (n < 0) check(1'b0, "ack_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        sync_vld = 1'b0;
        sync_v   = 1'b0;
    endtask

    // Called in cycle n+1: ce0 for address 0 at n+1, TVALID low at n+2 and high at n+3.
    task automatic check_start(input int n);
        @(negedge clk);
        check(ce0 && addr == 0 && cyc == n + 1, "start_ce0", {addr, 1'b0, ce0}, 64'd1);
        @(negedge clk);
        check(!tvalid, "start_tvalid_n2", 64'(tvalid), 64'd0);
        @(negedge clk);
        check(tvalid, "start_tvalid_n3", 64'(tvalid), 64'd1);
    endtask

    task automatic wait_done(output int fdc);
        fdc = -1;
        for (int i = 0; i < 2000 && fdc < 0; i++) begin
            @(negedge clk);
            if (frame_done) fdc = cyc;
        end
        if (fdc < 0) check(1'b0, "frame_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(!sync_ack, {tag, "_ack"}, 64'(sync_ack), 64'd0);
        check(!ce0, {tag, "_ce0"}, 64'(ce0), 64'd0);
        check(addr == 0, {tag, "_address0"}, 64'(addr), 64'd0);
        check(!tvalid, {tag, "_tvalid"}, 64'(tvalid), 64'd0);
        check(tdata == 0, {tag, "_tdata"}, 64'(tdata), 64'd0);
        check(!frame_done, {tag, "_frame_done"}, 64'(frame_done), 64'd0);
`ifdef ACT_BUF_READER_TLAST_EN
        check(!tlast, {tag, "_tlast"}, 64'(tlast), 64'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    int n, n2, fdc, acks, ces, tvs;
    bit fd;

    initial begin
        rst = 1'b1; sync_vld = 1'b0; sync_v = 1'b0;
        fill_pattern();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2 rst = 1'b0;

        // Continuous sink: 32 back-to-back bytes, frame_done one cycle after the last.
        mode = 0;
        raise_sync(1'b1);
        wait_ack(n, fd);
        check_start(n);
        wait_done(fdc);
        check(fdc == n + 3 + FB, "no_bubble_frame_done_cycle", 64'(fdc), 64'(n + 3 + FB));

        // Periodic backpressure.
        mode = 1;
        raise_sync(1'b1);
        wait_ack(n, fd);
        check_start(n);
        wait_done(fdc);

        // Sync with frame flag 0: acknowledged once, nothing streamed.
        mode = 0;
        raise_sync(1'b0);
        wait_ack(n, fd);
        acks = 0; ces = 0; tvs = 0;
        repeat (10) begin
            @(negedge clk);
            acks += int'(sync_ack);
            ces  += int'(ce0);
            tvs  += int'(tvalid);
        end
        check(acks == 0, "null_sync_extra_ack", 64'(acks), 64'd0);
        check(ces == 0, "null_sync_ce0", 64'(ces), 64'd0);
        check(tvs == 0, "null_sync_tvalid", 64'(tvs), 64'd0);

        // Random data with random backpressure.
        mode = 2;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            raise_sync(1'b1);
            wait_ack(n, fd);
            check_start(n);
            wait_done(fdc);
        end

        // Sync raised mid-frame and held: ack lands in the frame_done cycle.
        mode = 0;
        fill_pattern();
        raise_sync(1'b1);
        wait_ack(n, fd);
        check_start(n);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        sync_vld = 1'b1; sync_v = 1'b1;
        wait_ack(n2, fd);
        check(fd, "held_sync_ack_with_frame_done", 64'(fd), 64'd1);
        check(n2 == n + 3 + FB, "held_sync_ack_cycle", 64'(n2), 64'(n + 3 + FB));
        check_start(n2);
        wait_done(fdc);

        // Reset after 10 bytes of a frame, then restart from address 0.
        raise_sync(1'b1);
        wait_ack(n, fd);
        check_start(n);
        repeat (9) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        raise_sync(1'b1);
        wait_ack(n, fd);
        check_start(n);
        wait_done(fdc);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "leftover_expected_bytes", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
